// File: rtl/instr_buffer_pkg.sv
// Shared defaults for the instruction buffer: word width, queue depth and the
// RV32I NOP encoding that the output register holds after reset or flush.
package instr_buffer_pkg;
    localparam int          DEF_DATA_W     = 32;
    localparam int          DEF_DEPTH      = 4;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_WORD = NOP_WORD;
endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO holding the queue storage, wrap-around pointers and count.
// Full/empty come from the count so a full queue is never mistaken for empty.
module sync_fifo_core
    import instr_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; stale entries are never readable.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= d_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/instr_buffer.sv
// Instruction buffer: FIFO of fetched words feeding a registered instruction
// output, with same-cycle bypass when the queue is empty and flush priority.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0]  RESET_WORD = DATA_W'(DEF_RESET_WORD),
    localparam int                CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              in_ready_o,
    input  logic              enable_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] q_o,
    output logic              q_valid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic              push, pop, bypass;

    // Ready depends only on registered fullness and flush, never on enable_i.
    assign in_ready_o = !full_o && !flush_i;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = enable_i && !empty_o && !flush_i;
    assign bypass     = enable_i && empty_o && push;

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (flush_i),
        .push_i  (push && !bypass),
        .pop_i   (pop),
        .d_i     (d_i),
        .head_o  (head),
        .count_o (count_o),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    always_comb begin
        q_d       = q_q;
        q_valid_d = q_valid_q;
        if (flush_i) begin
            q_d       = RESET_WORD;
            q_valid_d = 1'b0;
        end else if (enable_i) begin
            if (pop) begin
                q_d       = head;
                q_valid_d = 1'b1;
            end else if (bypass) begin
                q_d       = d_i;
                q_valid_d = 1'b1;
            end else begin
                q_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q       <= RESET_WORD;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
endmodule

// File: tb/tb_instr_buffer.sv
// Directed testbench for instr_buffer: hold, fill, concurrent push/pop,
// flush, bypass and reset scenarios with hand-computed expectations.
module tb_instr_buffer;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic [31:0] d_i;
    logic        in_ready_o;
    logic        enable_i;
    logic        flush_i;
    logic [31:0] q_o;
    logic        q_valid_o;
    logic [2:0]  count_o;
    logic        empty_o;
    logic        full_o;

    int checks = 0;
    int errors = 0;

    instr_buffer dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .d_i        (d_i),
        .in_ready_o (in_ready_o),
        .enable_i   (enable_i),
        .flush_i    (flush_i),
        .q_o        (q_o),
        .q_valid_o  (q_valid_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; in_valid_i = 1'b0; enable_i = 1'b0; flush_i = 1'b0; d_i = '0;
        tick();
        rst_ni = 1'b1;
        checks++; if (q_o !== 32'h00000013) begin errors++; $display("FAIL reset_q: got %h exp %h", q_o, 32'h00000013); end
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b exp 0", q_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready_o); end
    endtask

    task automatic test_hold();
        enable_i = 1'b1; in_valid_i = 1'b1; d_i = 32'hFFFFFFFF;
        tick();
        enable_i = 1'b0; d_i = 32'hEEEEEEEE;
        tick();
        in_valid_i = 1'b0;
        checks++; if (q_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_q: got %h exp FFFFFFFF", q_o); end
        checks++; if (q_valid_o !== 1'b1) begin errors++; $display("FAIL hold_qv: got %b exp 1", q_valid_o); end
        checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL hold_count: got %0d exp 1", count_o); end
        tick();
        checks++; if (q_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL hold_q2: got %h exp FFFFFFFF", q_o); end
        enable_i = 1'b1;
        tick();
        checks++; if (q_o !== 32'hEEEEEEEE) begin errors++; $display("FAIL hold_pop_q: got %h exp EEEEEEEE", q_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL hold_pop_count: got %0d exp 0", count_o); end
        tick();
        enable_i = 1'b0;
        checks++; if (q_o !== 32'hEEEEEEEE) begin errors++; $display("FAIL empty_pop_q: got %h exp EEEEEEEE", q_o); end
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL empty_pop_qv: got %b exp 0", q_valid_o); end
    endtask

    task automatic test_fill();
        logic [31:0] w;
        for (int i = 1; i <= 4; i++) begin
            in_valid_i = 1'b1; d_i = 32'h11111111 * i;
            tick();
        end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d exp 4", count_o); end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", full_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b exp 0", in_ready_o); end
        d_i = 32'h55555555;
        tick();
        in_valid_i = 1'b0;
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_5th: got %0d exp 4", count_o); end
        enable_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            w = 32'h11111111 * i;
            checks++; if (q_o !== w) begin errors++; $display("FAIL drain_q%0d: got %h exp %h", i, q_o, w); end
            checks++; if (q_valid_o !== 1'b1) begin errors++; $display("FAIL drain_qv%0d: got %b exp 1", i, q_valid_o); end
        end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", empty_o); end
        tick();
        enable_i = 1'b0;
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL drain_extra_qv: got %b exp 0", q_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        in_valid_i = 1'b1; enable_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d_i = 32'hB0000000 + i;
            tick();
        end
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL b2b_start_count: got %0d exp 2", count_o); end
        enable_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d_i = 32'hB0000000 + k + 2;
            tick();
            w = 32'hB0000000 + k;
            checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d exp 2", k, count_o); end
            checks++; if (q_o !== w) begin errors++; $display("FAIL b2b_q%0d: got %h exp %h", k, q_o, w); end
        end
        in_valid_i = 1'b0;
        tick();
        checks++; if (q_o !== 32'hB0000006) begin errors++; $display("FAIL b2b_tail6: got %h exp B0000006", q_o); end
        tick();
        checks++; if (q_o !== 32'hB0000007) begin errors++; $display("FAIL b2b_tail7: got %h exp B0000007", q_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b exp 1", empty_o); end
        enable_i = 1'b0;
    endtask

    task automatic test_flush();
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_i = 32'hC0000000 + i;
            tick();
        end
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", count_o); end
        flush_i = 1'b1; enable_i = 1'b1; d_i = 32'hDEADBEEF;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", in_ready_o); end
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", count_o); end
        checks++; if (q_o !== 32'h00000013) begin errors++; $display("FAIL flush_q: got %h exp 00000013", q_o); end
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL flush_qv: got %b exp 0", q_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b exp 1", empty_o); end
        tick();
        enable_i = 1'b0;
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL flush_dropped_qv: got %b exp 0", q_valid_o); end
        checks++; if (q_o !== 32'h00000013) begin errors++; $display("FAIL flush_dropped_q: got %h exp 00000013", q_o); end
    endtask

    task automatic test_bypass();
        enable_i = 1'b1; in_valid_i = 1'b1; d_i = 32'h00500093;
        tick();
        enable_i = 1'b0; in_valid_i = 1'b0;
        checks++; if (q_o !== 32'h00500093) begin errors++; $display("FAIL bypass_q: got %h exp 00500093", q_o); end
        checks++; if (q_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_qv: got %b exp 1", q_valid_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d exp 0", count_o); end
    endtask

    task automatic test_reset_midstream();
        in_valid_i = 1'b1;
        d_i = 32'hA1A1A1A1; tick();
        d_i = 32'hA2A2A2A2; tick();
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL mrst_pre_count: got %0d exp 2", count_o); end
        rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b1; d_i = 32'hA3A3A3A3;
        tick();
        rst_ni = 1'b1; enable_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
        checks++; if (q_o !== 32'h00000013) begin errors++; $display("FAIL mrst_q: got %h exp 00000013", q_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d exp 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL mrst_empty: got %b exp 1", empty_o); end
        checks++; if (q_valid_o !== 1'b0) begin errors++; $display("FAIL mrst_qv: got %b exp 0", q_valid_o); end
        in_valid_i = 1'b1;
        d_i = 32'hD0D0D0D0; tick();
        d_i = 32'hD1D1D1D1; tick();
        in_valid_i = 1'b0; enable_i = 1'b1;
        tick();
        checks++; if (q_o !== 32'hD0D0D0D0) begin errors++; $display("FAIL mrst_first: got %h exp D0D0D0D0", q_o); end
        tick();
        enable_i = 1'b0;
        checks++; if (q_o !== 32'hD1D1D1D1) begin errors++; $display("FAIL mrst_second: got %h exp D1D1D1D1", q_o); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_fill();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 Parameter RESET_WORD, default 32'h00000013 (NOP), zero-extended or truncated to DATA_W: value of q_o after reset and after flush.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  synchronous, active-low reset.
REQ-006 in_valid_i  in  1  fetch word presented on d_i.
REQ-007 d_i  in  DATA_W  fetched instruction word.
REQ-008 in_ready_o  out  1  buffer accepts d_i this cycle.
REQ-009 enable_i  in  1  advance request: load the next instruction into q_o.
REQ-010 flush_i  in  1  discard all queued and held instructions (branch or trap redirect).
REQ-011 q_o  out  DATA_W  current instruction register, registered output.
REQ-012 q_valid_o  out  1  q_o holds a live instruction.
REQ-013 count_o  out  $clog2(DEPTH+1)  number of queued entries, excluding q_o.
REQ-014 empty_o, full_o  out  1 each  count_o==0 and count_o==DEPTH respectively.

Function
REQ-015 Push fires when in_valid_i && in_ready_o; in_ready_o is asserted when !full_o && !flush_i, driven combinationally from registered state only (it does not depend on enable_i).
REQ-016 Pop fires when enable_i && !empty_o && !flush_i: the head entry loads into q_o, q_valid_o<=1 and the head pointer increments.
REQ-017 Bypass: if enable_i && empty_o && push fires in the same cycle, d_i loads directly into q_o and q_valid_o<=1; count is unchanged. Input-to-q_o latency is therefore 1 cycle.
REQ-018 If enable_i && empty_o && no push: q_o holds its value and q_valid_o<=0.
REQ-019 If enable_i==0: q_o and q_valid_o hold. This is the plain instruction-register hold behaviour.
REQ-020 Simultaneous push and pop with a non-empty queue: count is unchanged, both pointers advance, and order is preserved.
REQ-021 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full and empty are derived from count, never from pointer equality alone.
REQ-022 Flush has priority over push, pop and bypass: count<=0, both pointers<=0, q_o<=RESET_WORD, q_valid_o<=0, and d_i is ignored in that cycle.
REQ-023 Strict FIFO order: q_o presents words in exactly the order they were accepted.
REQ-024 A push while full cannot occur, because in_ready_o=0; a pop while empty is a no-op per REQ-018.

Reset
REQ-025 While rst_ni==0 at a clock edge: q_o<=RESET_WORD, q_valid_o<=0, count<=0, pointers<=0; therefore empty_o=1, full_o=0 and in_ready_o=1 once flush_i==0.
REQ-026 Reset overrides flush, push and enable. Queue storage contents are not reset and are never observable.
REQ-027 Reset asserted mid-stream discards all queued words; the first post-reset push is the first word to reach q_o.

Structure
REQ-028 Package instr_buffer_pkg holds the default DATA_W, DEPTH and RESET_WORD constants and the NOP encoding; instr_buffer imports it.
REQ-029 One sub-module, sync_fifo_core (storage, pointers, count), holds all queue state; instr_buffer adds the q_o register, bypass and flush priority.
REQ-030 No latches and no combinational path from enable_i to in_ready_o.

Verification
REQ-031 Hold: enable_i=1, in_valid_i=1, d_i=FFFFFFFF for one cycle, then enable_i=0, d_i=EEEEEEEE -> q_o=FFFFFFFF, q_valid_o=1, count_o=1 (EEEEEEEE queued).
REQ-032 Fill: push 4 words (11111111..44444444) with enable_i=0 -> full_o=1, in_ready_o=0 and a 5th word is not accepted; then 4 enables -> q_o yields 11111111..44444444 in order and empty_o=1.
REQ-033 Concurrent push and pop at count_o=2 for 6 cycles -> count_o stays 2 through pointer wrap and q_o matches the push order.
REQ-034 Flush with count_o=3 and simultaneous in_valid_i=1 -> the next cycle shows count_o=0, q_o=00000013, q_valid_o=0, and the offered word is dropped.
REQ-035 Bypass: empty queue, enable_i=1, in_valid_i=1, d_i=00500093 -> the next cycle shows q_o=00500093, q_valid_o=1, count_o=0.
REQ-036 Reset: rst_ni=0 for one cycle at count_o=2 -> q_o=00000013, count_o=0, empty_o=1.
